// File: rtl/seq_shifter.sv
// Multi-cycle LSL/LSR/ASR/ROR shifter: moves at most STEP bits per cycle
// and flags completion with a one-cycle done pulse.
module seq_shifter #(
  parameter int N    = 64,
  parameter int STEP = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [N-1:0]         a,
  input  logic [$clog2(N)-1:0] shamt,
  output logic [N-1:0]         y,
  output logic                 busy,
  output logic                 done
);

  // state   | meaning
  // S_IDLE  | waiting for start, y holds the last result
  // S_SHIFT | applying up to STEP bits of the latched op per cycle
  // S_DONE  | one-cycle done pulse, result valid on y
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam int SW = $clog2(N);
  localparam int CW = SW + 1;
  localparam logic [CW-1:0] STEP_C = (STEP >= N) ? CW'(N) : CW'(STEP);

  state_t        state_q;
  logic [SW-1:0] cnt_q;
  logic [1:0]    op_q;
  logic [N-1:0]  y_q;
  logic          busy_q;
  logic          done_q;

  logic [CW-1:0] cnt_ext_d;
  logic [CW-1:0] step_d;
  logic [CW-1:0] rot_d;
  logic [N-1:0]  y_d;

  // rot_d reaches N only when step_d is 0, which makes the ROR left term 0.
  always_comb begin
    cnt_ext_d = {1'b0, cnt_q};
    step_d    = (cnt_ext_d < STEP_C) ? cnt_ext_d : STEP_C;
    rot_d     = CW'(N) - step_d;
    y_d       = y_q;
    case (op_q)
      2'b00:   y_d = y_q << step_d;
      2'b01:   y_d = y_q >> step_d;
      2'b10:   y_d = N'($signed(y_q) >>> step_d);
      default: y_d = (y_q >> step_d) | (y_q << rot_d);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= 2'b00;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            y_q   <= a;
            cnt_q <= shamt;
            op_q  <= op;
            if (shamt == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_SHIFT;
              busy_q  <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          y_q   <= y_d;
          cnt_q <= cnt_q - step_d[SW-1:0];
          if (cnt_ext_d == step_d) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign y    = y_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: STEP=1 and STEP=4 instances checked every cycle
// against a result/latency model, plus hand-computed literal results.
module tb_seq_shifter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s   [2];
  logic        start_s [2];
  logic [1:0]  op_s    [2];
  logic [63:0] a_s     [2];
  logic [5:0]  sh_s    [2];
  logic [63:0] y_s     [2];
  logic        busy_s  [2];
  logic        done_s  [2];

  seq_shifter #(.N(64), .STEP(1)) u_s1 (
    .clk(clk), .reset(rst_s[0]), .start(start_s[0]), .op(op_s[0]),
    .a(a_s[0]), .shamt(sh_s[0]), .y(y_s[0]), .busy(busy_s[0]), .done(done_s[0]));

  seq_shifter #(.N(64), .STEP(4)) u_s4 (
    .clk(clk), .reset(rst_s[1]), .start(start_s[1]), .op(op_s[1]),
    .a(a_s[1]), .shamt(sh_s[1]), .y(y_s[1]), .busy(busy_s[1]), .done(done_s[1]));

  int n_checks = 0;
  int n_fail   = 0;

  // Model: result is the one-shot shift by shamt, available after ceil(shamt/STEP) busy cycles.
  bit          mv     [2];
  bit          mbusy  [2];
  bit          mdone  [2];
  bit          mknown [2];
  int          mrem   [2];
  logic [63:0] my     [2];
  logic [63:0] mres   [2];

  function automatic int step_of(int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic logic [63:0] ref_shift(logic [1:0] o, logic [63:0] v, int sh);
    case (o)
      2'b00:   return v << sh;
      2'b01:   return v >> sh;
      2'b10:   return $signed(v) >>> sh;
      default: return (sh == 0) ? v : ((v >> sh) | (v << (64 - sh)));
    endcase
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_s[d]) begin
        mv[d] = 1'b1; mbusy[d] = 1'b0; mdone[d] = 1'b0;
        my[d] = '0;   mknown[d] = 1'b1;
      end else if (mv[d]) begin
        if (mdone[d]) begin
          mdone[d] = 1'b0;
        end else if (mbusy[d]) begin
          mrem[d] = mrem[d] - 1;
          if (mrem[d] == 0) begin
            mbusy[d] = 1'b0; mdone[d] = 1'b1; my[d] = mres[d]; mknown[d] = 1'b1;
          end
        end else if (start_s[d]) begin
          mres[d] = ref_shift(op_s[d], a_s[d], int'(sh_s[d]));
          mrem[d] = (int'(sh_s[d]) + step_of(d) - 1) / step_of(d);
          if (mrem[d] == 0) begin
            mdone[d] = 1'b1; my[d] = mres[d]; mknown[d] = 1'b1;
          end else begin
            mbusy[d] = 1'b1; mknown[d] = 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (mv[d]) begin
        chk($sformatf("busy[%0d]", d), 64'(busy_s[d]), 64'(mbusy[d]));
        chk($sformatf("done[%0d]", d), 64'(done_s[d]), 64'(mdone[d]));
        if (mknown[d]) chk($sformatf("y[%0d]", d), y_s[d], my[d]);
      end
    end
  endtask

  task automatic wait_done(input int d, output int lat);
    lat = 0;
    while (!done_s[d] && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic run(input int d, input logic [1:0] o, input logic [63:0] av,
                     input logic [5:0] sh, input logic [63:0] exp_y, input int exp_lat,
                     input string name);
    int lat;
    op_s[d] = o; a_s[d] = av; sh_s[d] = sh; start_s[d] = 1'b1;
    tick();
    start_s[d] = 1'b0;
    a_s[d] = {$urandom, $urandom}; sh_s[d] = 6'($urandom); op_s[d] = 2'($urandom);
    wait_done(d, lat);
    chk({name, " latency"}, 64'(lat), 64'(exp_lat));
    chk({name, " result"}, y_s[d], exp_y);
    tick();
  endtask

  initial begin
    int lat;
    bit seen;
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b1; start_s[d] = 1'b0; op_s[d] = 2'b00; a_s[d] = '0; sh_s[d] = '0;
    end
    tick(); tick();
    rst_s[0] = 1'b0; rst_s[1] = 1'b0;
    tick();
    chk("reset y", y_s[0], 64'h0);

    run(0, 2'b00, 64'h1, 6'd2, 64'h4, 2, "lsl 1<<2");
    run(0, 2'b00, 64'h5, 6'd2, 64'h14, 2, "lsl 5<<2");
    run(0, 2'b01, 64'h8000_0000_0000_0000, 6'd63, 64'h1, 63, "lsr 63");
    run(0, 2'b10, 64'h8000_0000_0000_0000, 6'd4, 64'hF800_0000_0000_0000, 4, "asr neg 4");
    run(0, 2'b10, 64'h40, 6'd3, 64'h8, 3, "asr pos 3");
    run(0, 2'b11, 64'h1, 6'd1, 64'h8000_0000_0000_0000, 1, "ror 1");
    run(0, 2'b11, 64'hDEAD, 6'd0, 64'hDEAD, 0, "ror zero");
    run(0, 2'b10, 64'hDEAD, 6'd0, 64'hDEAD, 0, "asr zero");

    run(1, 2'b00, 64'h5, 6'd6, 64'h140, 2, "s4 lsl 6");
    run(1, 2'b11, 64'hF, 6'd8, 64'h0F00_0000_0000_0000, 2, "s4 ror 8");
    run(1, 2'b10, 64'h8000_0000_0000_0000, 6'd5, 64'hFC00_0000_0000_0000, 2, "s4 asr 5");
    run(1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 64'h1, 16, "s4 lsr 63");
    run(1, 2'b11, 64'h1, 6'd3, 64'h2000_0000_0000_0000, 1, "s4 ror 3");
    run(1, 2'b00, 64'hDEAD, 6'd0, 64'hDEAD, 0, "s4 lsl zero");

    // start pulsed mid-shift must be ignored
    op_s[0] = 2'b00; a_s[0] = 64'h1; sh_s[0] = 6'd10; start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    tick(); tick();
    op_s[0] = 2'b01; a_s[0] = 64'hFF; sh_s[0] = 6'd1; start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    wait_done(0, lat);
    chk("ignored start latency", 64'(lat + 3), 64'd10);
    chk("ignored start result", y_s[0], 64'h400);
    tick();

    // reset mid-shift aborts without a done pulse
    op_s[0] = 2'b00; a_s[0] = 64'h1; sh_s[0] = 6'd10; start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    tick(); tick(); tick();
    rst_s[0] = 1'b1;
    tick();
    rst_s[0] = 1'b0;
    chk("abort y", y_s[0], 64'h0);
    chk("abort busy", 64'(busy_s[0]), 64'h0);
    chk("abort done", 64'(done_s[0]), 64'h0);
    seen = 1'b0;
    repeat (15) begin
      tick();
      if (done_s[0]) seen = 1'b1;
    end
    chk("abort no done", 64'(seen), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
Parametrised, multi-cycle shift unit that generalises the fixed shift-left-by-2 to variable amounts and four modes: LSL, LSR, ASR and ROR. Each cycle it shifts by up to STEP bits, trading latency for area. It has a start/busy/done handshake and is used by the LEGv8 datapath for shift-class instructions (LSL/LSR immediate) and by the branch-offset path when a variable scale is needed.

Parameters:
N, 64, data width in bits; must be a power of two, at least 2.
STEP, 1, maximum bits shifted per cycle; legal range 1..N.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
op  input  2  mode: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
a  input  N  operand; captured when start is accepted.
shamt  input  $clog2(N)  shift amount; captured when start is accepted.
y  output  N  working/result register.
busy  output  1  high while in SHIFT.
done  output  1  one-cycle pulse; result valid on y.

Behaviour:
- Reset: on any edge with reset=1, go to IDLE with y=0, busy=0, done=0 and counter=0. Reset wins over every other input, including mid-shift; an aborted operation produces no done.
- States: IDLE, SHIFT, DONE. busy=1 only in SHIFT; done=1 only in DONE.
- IDLE, start=1 at edge k:
  - Load y<=a, cnt<=shamt, latch op.
  - If shamt=0, go to DONE; otherwise go to SHIFT.
- IDLE, start=0: hold state; y holds its previous value.
- SHIFT, each edge:
  - s = min(STEP, cnt).
  - Apply the latched op by s to y.
  - cnt <= cnt - s.
  - If cnt - s = 0, go to DONE.
- Shift rules per step:
  - LSL: zero fill from the LSB.
  - LSR: zero fill from the MSB.
  - ASR: replicate the MSB of y as it stands at that step; the sign is preserved across steps.
  - ROR: bits leaving the LSB enter the MSB.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally. start is ignored in DONE; back-to-back operations are accepted from IDLE.
- Latency: done is high in the cycle following edge k + ceil(shamt/STEP). Example: shamt=0 gives done in the cycle right after edge k.
- y holds the result after DONE until the next accepted start. During SHIFT, y carries intermediate values and is not valid.
- start during SHIFT or DONE is ignored, and a, shamt and op may change freely then. Only the captured values are used.
- The final result equals the single-cycle operation by shamt for every STEP value.
- No overflow or flag outputs. shamt is always below N because of its port width.

Test Plan:
1. N=64, STEP=1: LSL, a=1, shamt=2 -> done 2 edges after start, y=4. Repeat with a=5 -> y=20, matching the legacy sl2 results.
2. LSR, a=0x8000_0000_0000_0000, shamt=63 -> busy high for 63 cycles, then done pulse, y=1.
3. ASR, a=0x8000_0000_0000_0000, shamt=4 -> y=0xF800_0000_0000_0000. ASR, a=0x40, shamt=3 -> y=0x8.
4. ROR, a=1, shamt=1 -> y=0x8000_0000_0000_0000. Any op with shamt=0 and a=0xDEAD -> done in the cycle after start, busy never high, y=0xDEAD.
5. Start LSL a=1 shamt=10. Pulse start with other data at cycle 3 -> ignored, final y=0x400. Then a new run with reset asserted at cycle 4 -> next edge y=0, busy=0, done=0, and no done pulse follows.
6. STEP=4 instance: LSL, a=5, shamt=6 -> done 2 edges after start, y=0x140. ROR, a=0xF, shamt=8 -> y=0x0F00_0000_0000_0000 after 2 edges.
